ows_rd_interface: RTL and testbench

//  1-Wire slave receive front end. It sits upstream of the presence-pulse transmitter and drives its
//  snd_prsnc/stop_flg inputs. It samples the shared bus, measures each low period and classifies it
//  as glitch, write-1 slot, write-0 slot or master reset pulse. Received bits are assembled LSB-first

---
 rtl/ows_rd_interface.sv | 133 +++++++++++++
 tb/tb_ows_rd_interface.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ows_rd_interface.sv
// 1-Wire slave receive front end: synchronises the bus, measures each low period and
// classifies it as glitch, write-1 slot, write-0 slot or master reset pulse. Bits are
// assembled LSB-first into bytes; reset pulses drive the presence transmitter handshake.
module ows_rd_interface #(
    parameter int unsigned GLITCH_MIN = 25,    // shortest low period that counts as a slot
    parameter int unsigned BIT_THR    = 750,   // low below this is a 1, otherwise a 0
    parameter int unsigned RST_MIN    = 24000, // low at or above this is a reset pulse
    parameter int unsigned BLANK      = 24000  // bus-ignore window covering our own presence
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       data_in_i,
    output logic       snd_prsnc_o,
    output logic       stop_flg_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic [2:0] bit_cnt_o
);

    localparam logic [31:0] GlitchMinC = 32'(GLITCH_MIN);
    localparam logic [31:0] BitThrC    = 32'(BIT_THR);
    localparam logic [31:0] RstMinC    = 32'(RST_MIN);
    localparam logic [31:0] BlankLastC = 32'(BLANK) - 32'd1;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StBlank
    } state_e;

    state_e      state_q;
    logic        s1_q, s2_q, s2_dly_q;
    logic [31:0] cnt_q;
    logic [31:0] blank_cnt_q;
    logic [7:0]  sh_q;
    logic [7:0]  rx_byte_q;
    logic [2:0]  bit_cnt_q;
    logic        snd_prsnc_q, stop_flg_q, rx_valid_q;

    logic fall, rise, rx_bit;
    logic [7:0] sh_next;

    // Edge detection on the synchronised bus and classification of the finished slot.
    always_comb begin
        fall    = s2_dly_q & ~s2_q;
        rise    = ~s2_dly_q & s2_q;
        rx_bit  = (cnt_q < BitThrC);
        sh_next = {rx_bit, sh_q[7:1]};
    end

    // Two-flop synchroniser plus one delay stage for edge detection; idle bus is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s2_dly_q <= 1'b1;
        end else begin
            s1_q     <= data_in_i;
            s2_q     <= s1_q;
            s2_dly_q <= s2_q;
        end
    end

    // Slot-measuring FSM with registered pulse outputs and byte assembly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            blank_cnt_q <= '0;
            sh_q        <= '0;
            rx_byte_q   <= '0;
            bit_cnt_q   <= '0;
            snd_prsnc_q <= 1'b0;
            stop_flg_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            snd_prsnc_q <= 1'b0;
            stop_flg_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q <= StLow;
                        cnt_q   <= 32'd1;
                    end
                end
                StLow: begin
                    if (rise) begin
                        state_q <= StIdle;
                        if (cnt_q == RstMinC) begin
                            // stop_flg already fired when the count saturated, so it leads.
                            snd_prsnc_q <= 1'b1;
                            blank_cnt_q <= '0;
                            state_q     <= StBlank;
                        end else if (cnt_q >= GlitchMinC) begin
                            sh_q <= sh_next;
                            if (bit_cnt_q == 3'd7) begin
                                rx_byte_q  <= sh_next;
                                rx_valid_q <= 1'b1;
                                bit_cnt_q  <= 3'd0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end else if (cnt_q < RstMinC) begin
                        cnt_q <= cnt_q + 32'd1;
                        if (cnt_q + 32'd1 == RstMinC) begin
                            // Reset pulse recognised: abort transmitter, drop partial byte.
                            stop_flg_q <= 1'b1;
                            sh_q       <= '0;
                            bit_cnt_q  <= '0;
                        end
                    end
                end
                StBlank: begin
                    if (blank_cnt_q >= BlankLastC) begin
                        state_q <= StIdle;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign snd_prsnc_o = snd_prsnc_q;
    assign stop_flg_o  = stop_flg_q;
    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: tb/tb_ows_rd_interface.sv
// Self-checking bench for ows_rd_interface with scaled-down timing parameters.
module tb_ows_rd_interface;

    localparam int unsigned GMin  = 5;
    localparam int unsigned BThr  = 40;
    localparam int unsigned RMin  = 400;
    localparam int unsigned Blnk  = 400;
    localparam int unsigned Low1  = 20;
    localparam int unsigned Low0  = 100;
    localparam int unsigned Gap   = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b1;
    logic       snd_prsnc, stop_flg, rx_valid;
    logic [7:0] rx_byte;
    logic [2:0] bit_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stop_cnt = 0;
    int prs_cnt  = 0;
    int overlap_cnt = 0;
    int rx_extra = 0;
    int stop_cyc = 0;
    int prs_cyc  = 0;
    int fall_cyc = 0;
    int rel_cyc  = 0;
    logic [7:0] exp_q[$];

    ows_rd_interface #(
        .GLITCH_MIN(GMin),
        .BIT_THR   (BThr),
        .RST_MIN   (RMin),
        .BLANK     (Blnk)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_in_i  (data_in),
        .snd_prsnc_o(snd_prsnc),
        .stop_flg_o (stop_flg),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .bit_cnt_o  (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on every rx_valid and tallies pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() > 0) check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
                else rx_extra++;
            end
            if (stop_flg) begin stop_cnt++; stop_cyc = cyc; end
            if (snd_prsnc) begin prs_cnt++; prs_cyc = cyc; end
            if (stop_flg && snd_prsnc) overlap_cnt++;
        end
    end

    task automatic send_low(input int unsigned n);
        @(negedge clk);
        data_in  = 1'b0;
        fall_cyc = cyc;
        repeat (n) @(negedge clk);
        data_in = 1'b1;
        rel_cyc = cyc;
        repeat (Gap) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        send_low(b ? Low1 : Low0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch);
        logic [7:0] v;
        v = b;
        exp_q.push_back(b);
        for (int i = 0; i < 8; i++) begin
            if (glitch) send_low(3);
            send_bit(v[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0, p0;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_snd", {31'h0, snd_prsnc}, 32'h0);
        check("rst_stop", {31'h0, stop_flg}, 32'h0);
        check("rst_byte", {24'h0, rx_byte}, 32'h0);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_bitcnt", {29'h0, bit_cnt}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: long reset pulse, presence timing, blanking window
        send_low(RMin + 200);
        check("t1_stop_cnt", stop_cnt, 1);
        check("t1_prs_cnt", prs_cnt, 1);
        check("t1_stop_lat", stop_cyc - fall_cyc, RMin + 2);
        check("t1_prs_lat", prs_cyc - rel_cyc, 3);
        repeat (40) @(negedge clk);
        send_low(Low1);
        check("t1_blank_ign", {29'h0, bit_cnt}, 32'h0);
        repeat (300) @(negedge clk);
        check("t1_after_blank", {29'h0, bit_cnt}, 32'h0);
        send_low(Low1);
        check("t1_bit_after", {29'h0, bit_cnt}, 32'h1);

        // 2: plain byte
        do_reset();
        send_byte(8'hA5, 1'b0);
        check("t2_bitcnt", {29'h0, bit_cnt}, 32'h0);

        // 3: glitches between bits add nothing
        send_byte(8'h3C, 1'b1);
        check("t3_bitcnt", {29'h0, bit_cnt}, 32'h0);

        // 4: classification boundaries (bits 1,1,0,0 then 1,0,1,0 -> 8'h53)
        s0 = stop_cnt;
        exp_q.push_back(8'h53);
        send_low(GMin - 1);
        check("t4_glitch", {29'h0, bit_cnt}, 32'h0);
        send_low(GMin);
        check("t4_gmin", {29'h0, bit_cnt}, 32'h1);
        send_low(BThr - 1);
        check("t4_thr_m1", {29'h0, bit_cnt}, 32'h2);
        send_low(BThr);
        check("t4_thr", {29'h0, bit_cnt}, 32'h3);
        send_low(RMin - 1);
        check("t4_rmin_m1", {29'h0, bit_cnt}, 32'h4);
        check("t4_no_stop", stop_cnt, s0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t4_bitcnt", {29'h0, bit_cnt}, 32'h0);

        // 5: partial byte discarded by reset pulse
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t5_partial", {29'h0, bit_cnt}, 32'h4);
        send_low(RMin + 100);
        check("t5_cleared", {29'h0, bit_cnt}, 32'h0);
        check("t5_stop_cnt", stop_cnt, s0 + 1);
        repeat (Blnk + 20) @(negedge clk);
        send_byte(8'h0F, 1'b0);
        check("t5_bitcnt", {29'h0, bit_cnt}, 32'h0);

        // 6: asynchronous reset mid-slot
        p0 = prs_cnt;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        data_in = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_snd", {31'h0, snd_prsnc}, 32'h0);
        check("t6_stop", {31'h0, stop_flg}, 32'h0);
        check("t6_byte", {24'h0, rx_byte}, 32'h0);
        check("t6_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_bitcnt", {29'h0, bit_cnt}, 32'h0);
        @(negedge clk);
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_prs", prs_cnt, p0);
        send_byte(8'hC3, 1'b0);
        check("t6_bitcnt_end", {29'h0, bit_cnt}, 32'h0);

        // Global scoreboard checks
        repeat (20) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("rx_extra", rx_extra, 0);
        check("overlap", overlap_cnt, 0);
        check("stop_total", stop_cnt, 2);
        check("prs_total", prs_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
